// File: rtl/usb_ahb_pkg.sv
// Shared constants for the USB endpoint AHB-Lite slave: register offsets,
// bus FSM states, status/error bit positions and the byte-lane helper.
package usb_ahb_pkg;

    localparam logic [3:0] OFF_FIFO   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_ERROR  = 4'h6;
    localparam logic [3:0] OFF_OCC    = 4'h8;
    localparam logic [3:0] OFF_TXSIZE = 4'hC;
    localparam logic [3:0] OFF_IRQEN  = 4'hE;

    localparam int unsigned ST_RX_READY  = 0;
    localparam int unsigned ST_RX_ACTIVE = 1;
    localparam int unsigned ST_TX_ACTIVE = 2;
    localparam int unsigned ST_TX_DONE   = 8;
    localparam int unsigned ER_RX        = 0;
    localparam int unsigned ER_TX        = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_DATA,
        ERR1,
        ERR2
    } ahb_state_t;

    // Byte lanes touched by an access; all-zero marks a misaligned or illegal size.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] m;
        m = '0;
        case (size)
            2'd0: m = 4'b0001 << addr;
            2'd1: if (!addr[0]) m = addr[1] ? 4'b1100 : 4'b0011;
            2'd2: if (addr == 2'b00) m = 4'b1111;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/usb_ep_regs.sv
// Per-endpoint register state: sticky status/error bits, tx packet size,
// interrupt enable, buffer reservation and the endpoint's interrupt term.
module usb_ep_regs
    import usb_ahb_pkg::*;
#(
    parameter int OCC_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_ready,
    input  logic             rx_active,
    input  logic             tx_active,
    input  logic             rx_error,
    input  logic             tx_error,
    input  logic [OCC_W-1:0] occupancy,
    input  logic             status_clr,
    input  logic [1:0]       err_clr,
    input  logic             size_we,
    input  logic [7:0]       size_wdata,
    input  logic             irq_en_we,
    input  logic [7:0]       irq_en_wdata,
    output logic [15:0]      status,
    output logic [15:0]      error,
    output logic [7:0]       tx_size,
    output logic [7:0]       irq_en,
    output logic             reserved,
    output logic             irq
);

    logic tx_active_q, rx_ready_q, tx_done, rx_err, tx_err;
    logic res_set, res_clr;

    assign res_set = (size_we && size_wdata != 8'h00) || (rx_ready && !rx_ready_q);
    assign res_clr = (occupancy == '0) && !rx_active && !tx_active;

    // Every sticky bit gives priority to its set source over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_active_q <= 1'b0;
            rx_ready_q  <= 1'b0;
            tx_done     <= 1'b0;
            rx_err      <= 1'b0;
            tx_err      <= 1'b0;
            tx_size     <= '0;
            irq_en      <= '0;
            reserved    <= 1'b0;
        end else begin
            tx_active_q <= tx_active;
            rx_ready_q  <= rx_ready;
            if (tx_active_q && !tx_active) tx_done <= 1'b1;
            else if (status_clr)           tx_done <= 1'b0;
            if (rx_error)        rx_err <= 1'b1;
            else if (err_clr[0]) rx_err <= 1'b0;
            if (tx_error)        tx_err <= 1'b1;
            else if (err_clr[1]) tx_err <= 1'b0;
            if (size_we)   tx_size <= size_wdata;
            if (irq_en_we) irq_en  <= irq_en_wdata;
            if (res_set)      reserved <= 1'b1;
            else if (res_clr) reserved <= 1'b0;
        end
    end

    always_comb begin
        status               = '0;
        status[ST_RX_READY]  = rx_ready;
        status[ST_RX_ACTIVE] = rx_active;
        status[ST_TX_ACTIVE] = tx_active;
        status[ST_TX_DONE]   = tx_done;
        error                = '0;
        error[ER_RX]         = rx_err;
        error[ER_TX]         = tx_err;
    end

    assign irq = |((status[7:0] | {6'b0, error[ER_TX], error[ER_RX]}) & irq_en);

endmodule

// File: rtl/usb_ahb_slave_mc.sv
// AHB-Lite slave exposing NUM_EP USB endpoint channels: FIFO data port,
// status/error/occupancy registers, tx size and interrupt enable per endpoint.
module usb_ahb_slave_mc
    import usb_ahb_pkg::*;
#(
    parameter int NUM_EP = 2,
    parameter int OCC_W  = 7
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic                    hsel,
    input  logic [7:0]              haddr,
    input  logic [1:0]              htrans,
    input  logic [1:0]              hsize,
    input  logic                    hwrite,
    input  logic [31:0]             hwdata,
    output logic [31:0]             hrdata,
    output logic                    hready,
    output logic                    hresp,
    input  logic [NUM_EP-1:0]       rxDataReady,
    input  logic [NUM_EP-1:0]       rxTransferActive,
    input  logic [NUM_EP-1:0]       txTransferActive,
    input  logic [NUM_EP-1:0]       rxError,
    input  logic [NUM_EP-1:0]       txError,
    input  logic [NUM_EP*OCC_W-1:0] bufferOccupancy,
    input  logic [NUM_EP*32-1:0]    rxData,
    output logic [NUM_EP-1:0]       getRxData,
    output logic [NUM_EP-1:0]       storeTxData,
    output logic [31:0]             txData,
    output logic [1:0]              dataSize,
    output logic [NUM_EP-1:0]       bufferReserved,
    output logic [NUM_EP*8-1:0]     txPacketDataSize,
    output logic                    irq
);

    ahb_state_t state, state_nx;
    logic [1:0] ep_q, word_q, size_q;
    logic [3:0] mask_q, mask_a, rdy4, act4;
    logic       take, fifo_a, bad_a, is_fifo_wr;
    logic [31:0] reg_word, lane_mask;

    logic [15:0] st_a [4];
    logic [15:0] er_a [4];
    logic [7:0]  sz_a [4];
    logic [7:0]  en_a [4];
    logic [31:0] occ_a [4];
    logic [31:0] rx_a [4];
    logic [3:0]  irq_v;
    logic        unused_ok;

    assign unused_ok = ^{haddr[7:6], htrans[0]};
    assign rdy4      = 4'(rxDataReady);
    assign act4      = 4'(rxTransferActive);

    assign hready = !(state == RD_WAIT || state == ERR1);
    assign hresp  = (state == ERR1 || state == ERR2);
    assign take   = hready && hsel && htrans[1];

    // All legality checks happen in the address phase so the data phase
    // never issues a strobe for a transfer that is going to error.
    assign mask_a = byte_mask(hsize, haddr[1:0]);
    assign fifo_a = haddr[3:2] == OFF_FIFO[3:2];
    always_comb begin
        bad_a = ({1'b0, haddr[5:4]} >= 3'(NUM_EP)) || (mask_a == '0) ||
                (fifo_a && haddr[1:0] != 2'b00);
        if (hwrite)
            bad_a = bad_a || (fifo_a && act4[haddr[5:4]]) ||
                    (haddr[3:2] == OFF_OCC[3:2]) ||
                    (haddr[3:2] == OFF_STATUS[3:2] && |mask_a[1:0]);
        else
            bad_a = bad_a || (fifo_a && !rdy4[haddr[5:4]]);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state  <= IDLE;
            ep_q   <= '0;
            word_q <= '0;
            size_q <= '0;
            mask_q <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                ep_q   <= haddr[5:4];
                word_q <= haddr[3:2];
                size_q <= hsize;
                mask_q <= mask_a;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            RD_WAIT: state_nx = RD_DATA;
            ERR1:    state_nx = ERR2;
            default: state_nx = IDLE;
        endcase
        if (take) begin
            if (bad_a)       state_nx = ERR1;
            else if (hwrite) state_nx = WRITE;
            else if (fifo_a) state_nx = RD_WAIT;
            else             state_nx = RD_DATA;
        end
    end

    assign is_fifo_wr = (state == WRITE) && (word_q == OFF_FIFO[3:2]);

    always_comb begin
        getRxData   = '0;
        storeTxData = '0;
        for (int unsigned i = 0; i < NUM_EP; i++) begin
            getRxData[i]   = (state == RD_WAIT) && (32'(ep_q) == i);
            storeTxData[i] = is_fifo_wr && (32'(ep_q) == i);
        end
        txData   = is_fifo_wr ? hwdata : '0;
        dataSize = is_fifo_wr ? size_q : '0;
    end

    always_comb begin
        lane_mask = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};
        case (word_q)
            OFF_STATUS[3:2]: reg_word = {er_a[ep_q], st_a[ep_q]};
            OFF_OCC[3:2]:    reg_word = occ_a[ep_q];
            OFF_TXSIZE[3:2]: reg_word = {8'h00, en_a[ep_q], 8'h00, sz_a[ep_q]};
            default:         reg_word = rx_a[ep_q];
        endcase
        hrdata = (state == RD_DATA) ? (reg_word & lane_mask) : '0;
    end

    for (genvar g = 0; g < 4; g++) begin : g_ep
        if (g < NUM_EP) begin : g_on
            logic sel_wr, sel_rd;
            assign sel_wr = (state == WRITE) && (ep_q == 2'(g));
            assign sel_rd = (state == RD_DATA) && (ep_q == 2'(g));
            assign rx_a[g]  = rxData[g*32 +: 32];
            assign occ_a[g] = 32'(bufferOccupancy[g*OCC_W +: OCC_W]);

            usb_ep_regs #(.OCC_W(OCC_W)) u_ep (
                .clk          (clk),
                .rst_n        (nRst),
                .rx_ready     (rxDataReady[g]),
                .rx_active    (rxTransferActive[g]),
                .tx_active    (txTransferActive[g]),
                .rx_error     (rxError[g]),
                .tx_error     (txError[g]),
                .occupancy    (bufferOccupancy[g*OCC_W +: OCC_W]),
                .status_clr   (sel_rd && word_q == OFF_STATUS[3:2] && |mask_q[1:0]),
                .err_clr      ({sel_wr && word_q == OFF_ERROR[3:2] && mask_q[3] && hwdata[24],
                                sel_wr && word_q == OFF_ERROR[3:2] && mask_q[2] && hwdata[16]}),
                .size_we      (sel_wr && word_q == OFF_TXSIZE[3:2] && mask_q[0]),
                .size_wdata   (hwdata[7:0]),
                .irq_en_we    (sel_wr && word_q == OFF_IRQEN[3:2] && mask_q[2]),
                .irq_en_wdata (hwdata[23:16]),
                .status       (st_a[g]),
                .error        (er_a[g]),
                .tx_size      (sz_a[g]),
                .irq_en       (en_a[g]),
                .reserved     (bufferReserved[g]),
                .irq          (irq_v[g])
            );
            assign txPacketDataSize[g*8 +: 8] = sz_a[g];
        end else begin : g_off
            assign st_a[g]  = '0;
            assign er_a[g]  = '0;
            assign sz_a[g]  = '0;
            assign en_a[g]  = '0;
            assign occ_a[g] = '0;
            assign rx_a[g]  = '0;
            assign irq_v[g] = 1'b0;
        end
    end

    assign irq = |irq_v;

endmodule

// File: tb/tb_usb_ahb_slave_mc.sv
// Directed bench for usb_ahb_slave_mc with NUM_EP=2: register access, FIFO
// strobes, error responses, sticky bits, pipelining and mid-transfer reset.
module tb_usb_ahb_slave_mc;

    logic        clk = 1'b0;
    logic        nRst;
    logic        hsel;
    logic [7:0]  haddr;
    logic [1:0]  htrans, hsize;
    logic        hwrite;
    logic [31:0] hwdata, hrdata, txData;
    logic        hready, hresp, irq;
    logic [1:0]  rxDataReady, rxTransferActive, txTransferActive, rxError, txError;
    logic [13:0] bufferOccupancy;
    logic [63:0] rxData;
    logic [1:0]  getRxData, storeTxData, dataSize, bufferReserved;
    logic [15:0] txPacketDataSize;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    usb_ahb_slave_mc #(.NUM_EP(2), .OCC_W(7)) dut (
        .clk              (clk),
        .nRst             (nRst),
        .hsel             (hsel),
        .haddr            (haddr),
        .htrans           (htrans),
        .hsize            (hsize),
        .hwrite           (hwrite),
        .hwdata           (hwdata),
        .hrdata           (hrdata),
        .hready           (hready),
        .hresp            (hresp),
        .rxDataReady      (rxDataReady),
        .rxTransferActive (rxTransferActive),
        .txTransferActive (txTransferActive),
        .rxError          (rxError),
        .txError          (txError),
        .bufferOccupancy  (bufferOccupancy),
        .rxData           (rxData),
        .getRxData        (getRxData),
        .storeTxData      (storeTxData),
        .txData           (txData),
        .dataSize         (dataSize),
        .bufferReserved   (bufferReserved),
        .txPacketDataSize (txPacketDataSize),
        .irq              (irq)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    task automatic addr_phase(input logic [7:0] a, input logic [1:0] s, input logic w);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hsize  = s;
        hwrite = w;
    endtask

    // Each returns mid data phase (negedge) so the caller can sample it.
    task automatic ahb_write(input logic [7:0] a, input logic [1:0] s, input logic [31:0] d);
        tick();
        addr_phase(a, s, 1'b1);
        tick();
        bus_idle();
        hwdata = d;
        @(negedge clk);
    endtask

    task automatic ahb_read(input logic [7:0] a, input logic [1:0] s);
        tick();
        addr_phase(a, s, 1'b0);
        tick();
        bus_idle();
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [1:0] size;
        logic       wr;
        string      tag;
    } err_vec_t;

    err_vec_t err_tab[5] = '{
        '{8'h30, 2'd2, 1'b0, "err_ep_range"},
        '{8'h10, 2'd2, 1'b0, "err_rx_not_ready"},
        '{8'h04, 2'd2, 1'b1, "err_wr_status"},
        '{8'h01, 2'd0, 1'b0, "err_unmapped"},
        '{8'h00, 2'd2, 1'b1, "err_wr_rx_active"}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nRst             = 1'b0;
        bus_idle();
        haddr            = '0;
        hsize            = '0;
        hwdata           = '0;
        rxDataReady      = '0;
        rxTransferActive = '0;
        txTransferActive = '0;
        rxError          = '0;
        txError          = '0;
        bufferOccupancy  = {7'd5, 7'd0};
        rxData           = {32'h1111_2222, 32'hDEAD_BEEF};

        #3;
        check("rst_hready", 32'(hready), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_strobes", 32'({getRxData, storeTxData}), 32'h0);
        check("rst_txdata", txData, 32'h0);
        check("rst_datasize", 32'(dataSize), 32'h0);
        check("rst_reserved", 32'(bufferReserved), 32'h0);
        check("rst_txsize", 32'(txPacketDataSize), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        tick();
        nRst = 1'b1;

        // tx size write on EP1 reserves its buffer
        ahb_write(8'h1C, 2'd0, 32'h0000_0040);
        check("txsize_wr_hready", 32'({hresp, hready}), 32'b01);
        check("txsize_wr_nostrobe", 32'(storeTxData), 32'h0);
        tick();
        @(negedge clk);
        check("txsize_value", 32'(txPacketDataSize), 32'h4000);
        check("txsize_reserved", 32'(bufferReserved), 32'b10);
        ahb_read(8'h1C, 2'd2);
        check("txsize_readback", hrdata, 32'h0000_0040);
        ahb_read(8'h18, 2'd2);
        check("occ_read", hrdata, 32'd5);

        // FIFO read with exactly one wait state
        tick();
        rxDataReady = 2'b01;
        ahb_read(8'h00, 2'd2);
        check("fifo_rd_wait_hready", 32'(hready), 32'd0);
        check("fifo_rd_get", 32'(getRxData), 32'b01);
        tick();
        @(negedge clk);
        check("fifo_rd_data_hready", 32'(hready), 32'd1);
        check("fifo_rd_get_done", 32'(getRxData), 32'b00);
        check("fifo_rd_hrdata", hrdata, 32'hDEAD_BEEF);

        // error responses: two cycles, no strobes
        tick();
        rxTransferActive = 2'b01;
        foreach (err_tab[k]) begin
            tick();
            addr_phase(err_tab[k].addr, err_tab[k].size, err_tab[k].wr);
            hwdata = 32'h1234_5678;
            tick();
            bus_idle();
            @(negedge clk);
            check({err_tab[k].tag, "_c1"}, 32'({hresp, hready}), 32'b10);
            check({err_tab[k].tag, "_strobe"}, 32'({getRxData, storeTxData}), 32'h0);
            tick();
            @(negedge clk);
            check({err_tab[k].tag, "_c2"}, 32'({hresp, hready}), 32'b11);
        end
        tick();
        rxTransferActive = 2'b00;
        @(negedge clk);
        check("err_recovered", 32'({hresp, hready}), 32'b01);

        // sticky txError vs W1C in same cycle, then irq enable
        ahb_write(8'h0E, 2'd0, 32'h0002_0000);
        tick();
        @(negedge clk);
        check("irq_off_initial", 32'(irq), 32'd0);
        tick();
        addr_phase(8'h06, 2'd1, 1'b1);
        tick();
        bus_idle();
        hwdata  = 32'h0100_0000;
        txError = 2'b01;
        tick();
        txError = 2'b00;
        @(negedge clk);
        check("txerr_set_wins_irq", 32'(irq), 32'd1);
        ahb_read(8'h06, 2'd1);
        check("txerr_set_wins_reg", hrdata, 32'h0100_0000);
        ahb_write(8'h06, 2'd1, 32'h0100_0000);
        tick();
        @(negedge clk);
        check("txerr_cleared_irq", 32'(irq), 32'd0);
        ahb_read(8'h06, 2'd1);
        check("txerr_cleared_reg", hrdata, 32'h0);
        ahb_write(8'h0E, 2'd0, 32'h0001_0000);
        tick();
        @(negedge clk);
        check("irq_rxready_en", 32'(irq), 32'd1);
        ahb_write(8'h0E, 2'd0, 32'h0000_0000);
        tick();
        @(negedge clk);
        check("irq_disabled", 32'(irq), 32'd0);

        // txDone sticky on txTransferActive fall, cleared by status read
        tick();
        txTransferActive = 2'b01;
        tick();
        txTransferActive = 2'b00;
        ahb_read(8'h04, 2'd1);
        check("status_txdone", hrdata, 32'h0000_0101);
        ahb_read(8'h04, 2'd1);
        check("status_txdone_clr", hrdata, 32'h0000_0001);

        // back-to-back FIFO writes without wait states
        tick();
        addr_phase(8'h00, 2'd2, 1'b1);
        tick();
        htrans = 2'b11;
        hwdata = 32'hA5A5_0001;
        @(negedge clk);
        check("b2b_store1", 32'(storeTxData), 32'b01);
        check("b2b_txdata1", txData, 32'hA5A5_0001);
        check("b2b_size1", 32'(dataSize), 32'd2);
        check("b2b_hready1", 32'(hready), 32'd1);
        tick();
        bus_idle();
        hwdata = 32'h5A5A_0002;
        @(negedge clk);
        check("b2b_store2", 32'(storeTxData), 32'b01);
        check("b2b_txdata2", txData, 32'h5A5A_0002);
        check("b2b_hready2", 32'(hready), 32'd1);
        tick();
        @(negedge clk);
        check("b2b_store_end", 32'(storeTxData), 32'b00);
        ahb_write(8'h10, 2'd0, 32'h0000_00C3);
        check("byte_fifo_store", 32'(storeTxData), 32'b10);
        check("byte_fifo_size", 32'(dataSize), 32'd0);
        check("byte_fifo_data", txData, 32'h0000_00C3);

        // reset during the FIFO read wait state aborts it
        ahb_read(8'h00, 2'd2);
        check("rst_mid_wait_get", 32'(getRxData), 32'b01);
        nRst = 1'b0;
        #1;
        check("rst_mid_hready", 32'(hready), 32'd1);
        check("rst_mid_get", 32'(getRxData), 32'b00);
        tick();
        tick();
        nRst = 1'b1;
        @(negedge clk);
        check("rst_rel_get", 32'(getRxData), 32'b00);
        check("rst_rel_hready", 32'({hresp, hready}), 32'b01);
        check("rst_rel_txsize", 32'(txPacketDataSize), 32'h0);
        tick();
        @(negedge clk);
        check("rst_rel_get2", 32'(getRxData), 32'b00);
        check("rst_rel_hrdata", hrdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
